// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives instruction_memory and registers IF/ID.
// Optional fetched-instruction counter is built when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
    parameter int                 ADDR_W    = 16,
    parameter int                 INSTR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] HALT_WORD = '1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic               halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_count
`endif
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;

    // The memory address comes straight from the PC register, so stall and
    // redirect never reach imem_addr combinationally.
    assign imem_addr = pc;
    assign halted    = (state == HALTED);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            state      <= RUN;
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_pc    <= '0;
`ifdef FETCH_PERF_CNT_EN
            fetch_count <= '0;
`endif
        end else if (redirect_valid) begin
            // Flush only the valid bit; the stale payload is harmless once invalid.
            pc         <= redirect_target;
            ifid_valid <= 1'b0;
            state      <= RUN;
        end else if (!stall) begin
            if (state == RUN) begin
                ifid_instr <= imem_instr;
                ifid_pc    <= pc;
                ifid_valid <= 1'b1;
`ifdef FETCH_PERF_CNT_EN
                fetch_count <= fetch_count + 32'd1;
`endif
                if (imem_instr == HALT_WORD) begin
                    state <= HALTED;
                end else begin
                    pc <= pc + ADDR_W'(1);
                end
            end else begin
                ifid_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: sequential fetch, stall, redirect,
// halt, PC wrap, mid-stream reset and (when FETCH_PERF_CNT_EN is defined) the counter.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic [15:0] imem_addr;
    logic [31:0] imem_instr;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:65535];

    assign imem_instr = mem[imem_addr];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .ifid_valid      (ifid_valid),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .halted          (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count     (fetch_count)
`endif
    );

    // Advance one rising edge and settle; inputs changed here are stable by the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ifid_valid, ifid_instr, ifid_pc, imem_addr, halted} !== {1'b0, 32'd0, 16'd0, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got valid=%b instr=%h pc=%h addr=%h halted=%b want 0/0/0/0/0",
                     ifid_valid, ifid_instr, ifid_pc, imem_addr, halted);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (fetch_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", fetch_count);
        end
`endif
    endtask

    task automatic test_seq_fetch();
        logic [31:0] exp_instr [4];
        exp_instr = '{32'd10, 32'd20, 32'd30, 32'd40};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({ifid_valid, ifid_pc, ifid_instr, imem_addr} !== {1'b1, 16'(i), exp_instr[i], 16'(i + 1)}) begin
                errors++;
                $display("FAIL seq_fetch[%0d]: got valid=%b pc=%h instr=%0d addr=%h want 1/%h/%0d/%h",
                         i, ifid_valid, ifid_pc, ifid_instr, imem_addr, 16'(i), exp_instr[i], 16'(i + 1));
            end
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (fetch_count !== 32'd4) begin
            errors++;
            $display("FAIL count_after_4: got %0d want 4", fetch_count);
        end
`endif
    endtask

    task automatic test_stall();
        do_reset();
        step();
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({ifid_valid, ifid_pc, ifid_instr, imem_addr} !== {1'b1, 16'd1, 32'd20, 16'd2}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got valid=%b pc=%h instr=%0d addr=%h want 1/0001/20/0002",
                         i, ifid_valid, ifid_pc, ifid_instr, imem_addr);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if ({ifid_valid, ifid_pc, ifid_instr, imem_addr} !== {1'b1, 16'd2, 32'd30, 16'd3}) begin
            errors++;
            $display("FAIL stall_release: got valid=%b pc=%h instr=%0d addr=%h want 1/0002/30/0003",
                     ifid_valid, ifid_pc, ifid_instr, imem_addr);
        end
        step();
        checks++;
        if ({ifid_pc, ifid_instr} !== {16'd3, 32'd40}) begin
            errors++;
            $display("FAIL stall_after: got pc=%h instr=%0d want 0003/40", ifid_pc, ifid_instr);
        end
    endtask

    // Redirect sampled together with stall: the redirect wins.
    task automatic test_redirect();
        redirect_valid  = 1'b1;
        redirect_target = 16'h0100;
        stall           = 1'b1;
        step();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        checks++;
        if ({ifid_valid, imem_addr, ifid_pc, ifid_instr} !== {1'b0, 16'h0100, 16'd3, 32'd40}) begin
            errors++;
            $display("FAIL redirect_flush: got valid=%b addr=%h pc=%h instr=%0d want 0/0100/0003/40",
                     ifid_valid, imem_addr, ifid_pc, ifid_instr);
        end
        step();
        checks++;
        if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, 16'h0100, 32'h1000_0100}) begin
            errors++;
            $display("FAIL redirect_target: got valid=%b pc=%h instr=%h want 1/0100/10000100",
                     ifid_valid, ifid_pc, ifid_instr);
        end
    endtask

    task automatic test_halt();
        redirect_valid  = 1'b1;
        redirect_target = 16'd4;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        checks++;
        if ({ifid_valid, ifid_pc, ifid_instr, halted, imem_addr} !== {1'b1, 16'd5, 32'hFFFF_FFFF, 1'b1, 16'd5}) begin
            errors++;
            $display("FAIL halt_word: got valid=%b pc=%h instr=%h halted=%b addr=%h want 1/0005/ffffffff/1/0005",
                     ifid_valid, ifid_pc, ifid_instr, halted, imem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({ifid_valid, halted, imem_addr} !== {1'b0, 1'b1, 16'd5}) begin
                errors++;
                $display("FAIL halted_hold[%0d]: got valid=%b halted=%b addr=%h want 0/1/0005",
                         i, ifid_valid, halted, imem_addr);
            end
        end
        redirect_valid  = 1'b1;
        redirect_target = 16'd0;
        step();
        redirect_valid = 1'b0;
        checks++;
        if ({ifid_valid, halted, imem_addr} !== {1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL halt_exit: got valid=%b halted=%b addr=%h want 0/0/0000",
                     ifid_valid, halted, imem_addr);
        end
        step();
        checks++;
        if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, 16'd0, 32'd10}) begin
            errors++;
            $display("FAIL halt_resume: got valid=%b pc=%h instr=%0d want 1/0000/10",
                     ifid_valid, ifid_pc, ifid_instr);
        end
    endtask

    task automatic test_wrap_reset();
        redirect_valid  = 1'b1;
        redirect_target = 16'hFFFF;
        step();
        redirect_valid = 1'b0;
        step();
        checks++;
        if ({ifid_valid, ifid_pc, ifid_instr, imem_addr} !== {1'b1, 16'hFFFF, 32'h1000_FFFF, 16'h0000}) begin
            errors++;
            $display("FAIL wrap_top: got valid=%b pc=%h instr=%h addr=%h want 1/ffff/1000ffff/0000",
                     ifid_valid, ifid_pc, ifid_instr, imem_addr);
        end
        step();
        checks++;
        if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, 16'h0000, 32'd10}) begin
            errors++;
            $display("FAIL wrap_zero: got valid=%b pc=%h instr=%0d want 1/0000/10",
                     ifid_valid, ifid_pc, ifid_instr);
        end
        step();
        rst             = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 16'h0042;
        stall           = 1'b1;
        step();
        checks++;
        if ({ifid_valid, ifid_instr, ifid_pc, imem_addr, halted} !== {1'b0, 32'd0, 16'd0, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL midstream_reset: got valid=%b instr=%h pc=%h addr=%h halted=%b want 0/0/0/0/0",
                     ifid_valid, ifid_instr, ifid_pc, imem_addr, halted);
        end
        rst            = 1'b0;
        redirect_valid = 1'b0;
        stall          = 1'b0;
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_count();
        test_seq_fetch();
        stall = 1'b1;
        step();
        step();
        stall = 1'b0;
        checks++;
        if (fetch_count !== 32'd4) begin
            errors++;
            $display("FAIL count_stall: got %0d want 4", fetch_count);
        end
        redirect_valid  = 1'b1;
        redirect_target = 16'd0;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (fetch_count !== 32'd4) begin
            errors++;
            $display("FAIL count_flush: got %0d want 4", fetch_count);
        end
        step();
        checks++;
        if (fetch_count !== 32'd5) begin
            errors++;
            $display("FAIL count_resume: got %0d want 5", fetch_count);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (fetch_count !== 32'd0) begin
            errors++;
            $display("FAIL count_reset: got %0d want 0", fetch_count);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 32'h1000_0000 + 32'(i);
        end
        mem[0] = 32'd10;
        mem[1] = 32'd20;
        mem[2] = 32'd30;
        mem[3] = 32'd40;
        mem[5] = 32'hFFFF_FFFF;

        rst             = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;

        test_reset();
        test_seq_fetch();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap_reset();
`ifdef FETCH_PERF_CNT_EN
        test_perf_count();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
